ibuf_ptr_ctl: RTL

- Pointer/occupancy controller for the IFU 16-byte circular instruction buffer.
- Consumes the one-hot byte-length codes the decode-side index adders produce: bit0 = no advance, bit k = k bytes consumed (k = 1..7).
- Rotates a one-hot read pointer by the consumed length and re-encodes it to a binary index for the byte muxes.
- Tracks fetch writes (4 bytes each) and exposes occupancy, full/empty and a fetch-ready handshake.

---
 rtl/ibuf_ptr_ctl.sv | 82 ++++++++
 1 files changed

// File: rtl/ibuf_ptr_ctl.sv
// rtl/ibuf_ptr_ctl.sv - read/write pointer and occupancy control for the IFU instruction buffer
module ibuf_ptr_ctl #(
    parameter int DEPTH       = 16,
    parameter int FETCH_BYTES = 4
) (
    input  logic                       clk,
    input  logic                       reset_l,
    input  logic                       flush,
    input  logic                       fetch_valid,
    output logic                       fetch_rdy,
    input  logic [7:0]                 drain_len,
    output logic [DEPTH-1:0]           rd_ptr_oh,
    output logic [$clog2(DEPTH)-1:0]   rd_idx,
    output logic [DEPTH-1:0]           wr_ptr_oh,
    output logic [$clog2(DEPTH+1)-1:0] byte_cnt,
    output logic                       ibuf_empty,
    output logic                       ibuf_full,
    output logic                       drain_err
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0]    CNT_MAX = CW'(DEPTH);
    localparam logic [CW-1:0]    RDY_MAX = CW'(DEPTH - FETCH_BYTES);
    localparam logic [CW-1:0]    FB_CNT  = CW'(FETCH_BYTES);
    localparam logic [IW-1:0]    FB_ROT  = IW'(FETCH_BYTES);
    localparam logic [DEPTH-1:0] PTR_RST = DEPTH'(1);

    // Rotate a one-hot pointer left, wrapping around the circular buffer.
    function automatic logic [DEPTH-1:0] rotl(input logic [DEPTH-1:0] x, input logic [IW-1:0] n);
        logic [2*DEPTH-1:0] t;
        t = {x, x} << n;
        return t[2*DEPTH-1:DEPTH];
    endfunction

    logic [2:0]    k;
    logic          drain_ok;
    logic          wr_go;
    logic [CW-1:0] cnt_next;

    always_comb begin
        k = '0;
        for (int i = 1; i < 8; i++) begin
            if (drain_len[i]) k = 3'(i);
        end
    end

    // Length is checked against the registered count only; a same-cycle write cannot fund a drain.
    assign drain_ok   = $onehot(drain_len) && (CW'(k) <= byte_cnt);
    assign fetch_rdy  = (byte_cnt <= RDY_MAX);
    assign wr_go      = fetch_valid && fetch_rdy;
    assign cnt_next   = byte_cnt + (wr_go ? FB_CNT : '0) - (drain_ok ? CW'(k) : '0);
    assign ibuf_empty = (byte_cnt == '0);
    assign ibuf_full  = (byte_cnt == CNT_MAX);

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            rd_ptr_oh <= PTR_RST;
            rd_idx    <= '0;
            wr_ptr_oh <= PTR_RST;
            byte_cnt  <= '0;
            drain_err <= 1'b0;
        end else if (flush) begin
            rd_ptr_oh <= PTR_RST;
            rd_idx    <= '0;
            wr_ptr_oh <= PTR_RST;
            byte_cnt  <= '0;
            drain_err <= 1'b0;
        end else begin
            if (wr_go) begin
                wr_ptr_oh <= rotl(wr_ptr_oh, FB_ROT);
            end
            if (drain_ok) begin
                rd_ptr_oh <= rotl(rd_ptr_oh, IW'(k));
                rd_idx    <= rd_idx + IW'(k);
            end
            byte_cnt  <= cnt_next;
            drain_err <= !drain_ok;
        end
    end

endmodule
